// File: rtl/mod9_counter_sched.sv
// ---------------------------------------------------------------------------
// mod9_counter_sched
//
// Sequencer/arbiter that shares one external loadable mod-9 up/down counter
// between two requesters. Each requester issues LOAD, UP-by-N or DOWN-by-N
// commands. Grants are round-robin. The scheduler drives the counter's
// load/control/I pins and reports the final count.
//
// The external counter steps on every clock unless it is loaded. Whenever no
// command is executing, the scheduler therefore holds the count by reloading
// the counter with its own output.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   req_i[1:0]     request per requester, held high until its ack is seen
//   cmd0_i/arg0_i  requester 0 command (00 NOP, 01 LOAD, 10 UP, 11 DOWN) and
//                  argument (load value or step count)
//   cmd1_i/arg1_i  requester 1 command and argument
//   ack_o[1:0]     one-cycle accept pulse per requester
//   done_o[1:0]    one-cycle completion pulse per requester
//   err_o          one-cycle pulse with done_o for a rejected command
//   result_o       count captured at completion, held until the next one
//   busy_o         high whenever the scheduler is not idle
//   cnt_load_o     to counter load
//   cnt_control_o  to counter control (1 = count up)
//   cnt_I_o        to counter parallel-load input
//   cnt_q_i        from counter output
// ---------------------------------------------------------------------------
module mod9_counter_sched #(
    parameter int MOD       = 9,
    parameter int MAX_STEPS = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] cmd0_i,
    input  logic [3:0] arg0_i,
    input  logic [1:0] cmd1_i,
    input  logic [3:0] arg1_i,
    output logic [1:0] ack_o,
    output logic [1:0] done_o,
    output logic       err_o,
    output logic [3:0] result_o,
    output logic       busy_o,
    output logic       cnt_load_o,
    output logic       cnt_control_o,
    output logic [3:0] cnt_I_o,
    input  logic [3:0] cnt_q_i
);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_UP   = 2'b10;
    localparam logic [1:0] CMD_DOWN = 2'b11;

    localparam logic [3:0] MOD_V   = 4'(MOD);
    localparam logic [3:0] MAX_V   = 4'(MAX_STEPS);

    // IDLE: waiting for a request, counter held.
    // EXEC: counter is loaded once or stepped step_q more times.
    // WAIT: counter held for one cycle while the final count is captured.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e     state_q,     state_d;
    logic       grantIdx_q,  grantIdx_d;
    logic       lastGrant_q, lastGrant_d;
    logic [1:0] cmd_q,       cmd_d;
    logic [3:0] arg_q,       arg_d;
    logic [3:0] stepCnt_q,   stepCnt_d;
    logic       invalid_q,   invalid_d;
    logic [1:0] ack_q,       ack_d;
    logic [1:0] done_q,      done_d;
    logic       err_q,       err_d;
    logic [3:0] result_q,    result_d;

    logic       grantSel;
    logic [1:0] selCmd;
    logic [3:0] selArg;
    logic       selValid;

    // Arbitration and command validation for the requester that would be
    // granted at the next edge. With both requesting, the one not granted
    // last wins; lastGrant_q resets to 1 so requester 0 is favoured first.
    always_comb begin
        grantSel = 1'b0;
        if (req_i == 2'b11) begin
            grantSel = ~lastGrant_q;
        end else begin
            grantSel = req_i[1];
        end

        selCmd = grantSel ? cmd1_i : cmd0_i;
        selArg = grantSel ? arg1_i : arg0_i;

        selValid = 1'b0;
        case (selCmd)
            CMD_LOAD: selValid = (selArg < MOD_V);
            CMD_UP,
            CMD_DOWN: selValid = (selArg != 4'd0) && (selArg <= MAX_V);
            default:  selValid = 1'b0;
        endcase
    end

    // Next-state logic. ack/done/err are single-cycle pulses, so they
    // default to zero and are raised only in the cycle before they appear.
    always_comb begin
        state_d     = state_q;
        grantIdx_d  = grantIdx_q;
        lastGrant_d = lastGrant_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        stepCnt_d   = stepCnt_q;
        invalid_d   = invalid_q;
        ack_d       = 2'b00;
        done_d      = 2'b00;
        err_d       = 1'b0;
        result_d    = result_q;

        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    grantIdx_d  = grantSel;
                    lastGrant_d = grantSel;
                    cmd_d       = selCmd;
                    arg_d       = selArg;
                    invalid_d   = ~selValid;
                    ack_d       = grantSel ? 2'b10 : 2'b01;
                    if (selValid) begin
                        // A LOAD occupies exactly one EXEC cycle.
                        state_d   = EXEC;
                        stepCnt_d = (selCmd == CMD_LOAD) ? 4'd1 : selArg;
                    end else begin
                        // Rejected commands never touch the counter.
                        state_d   = WAIT;
                        stepCnt_d = 4'd0;
                    end
                end
            end

            EXEC: begin
                if (stepCnt_q <= 4'd1) begin
                    state_d   = WAIT;
                    stepCnt_d = 4'd0;
                end else begin
                    stepCnt_d = stepCnt_q - 4'd1;
                end
            end

            WAIT: begin
                // The counter has been held this cycle, so cnt_q_i already
                // shows the final count of the command.
                result_d           = cnt_q_i;
                done_d[grantIdx_q] = 1'b1;
                err_d              = invalid_q;
                state_d            = IDLE;
            end

            default: begin
                state_d   = IDLE;
                stepCnt_d = 4'd0;
            end
        endcase
    end

    // State and registered outputs. Reset aborts any command in flight
    // without a done pulse; the counter pins fall back to hold at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            grantIdx_q  <= 1'b0;
            lastGrant_q <= 1'b1;
            cmd_q       <= CMD_NOP;
            arg_q       <= 4'd0;
            stepCnt_q   <= 4'd0;
            invalid_q   <= 1'b0;
            ack_q       <= 2'b00;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            result_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            grantIdx_q  <= grantIdx_d;
            lastGrant_q <= lastGrant_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            stepCnt_q   <= stepCnt_d;
            invalid_q   <= invalid_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
        end
    end

    // Counter pins follow the state directly. Outside EXEC the counter is
    // reloaded with its own value, which is how the count is held.
    always_comb begin
        cnt_load_o    = 1'b1;
        cnt_control_o = 1'b0;
        cnt_I_o       = cnt_q_i;
        if (state_q == EXEC) begin
            if (cmd_q == CMD_LOAD) begin
                cnt_I_o = arg_q;
            end else begin
                cnt_load_o    = 1'b0;
                cnt_control_o = (cmd_q == CMD_UP);
                cnt_I_o       = 4'd0;
            end
        end
    end

    assign ack_o    = ack_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign result_o = result_q;
    assign busy_o   = (state_q != IDLE);

endmodule
